// File: rtl/udp_gen_pkg.sv
// udp_gen_pkg: shared types, lengths and checksum helpers
// for the Ethernet/IPv4/UDP test frame generator.
package udp_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREP,
      ST_SEND,
      ST_GAP
   } state_t;

   localparam logic [15:0] ETH_HDR_LEN    = 16'd14;
   localparam logic [15:0] IP_HDR_LEN     = 16'd20;
   localparam logic [15:0] UDP_HDR_LEN    = 16'd8;
   localparam logic [15:0] HDR_LEN        = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;
   localparam logic [15:0] MIN_PAYLOAD    = 16'd18;
   localparam logic [15:0] MAX_PAYLOAD    = 16'd1472;
   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

   // Fold a wide sum back into 16 bits with end-around carry, twice.
   function automatic logic [15:0] csum_fold(input logic [19:0] s);
      logic [16:0] t;
      t = {1'b0, s[15:0]} + {13'd0, s[19:16]};
      return t[15:0] + {15'd0, t[16]};
   endfunction

   function automatic logic [15:0] clamp_len(input logic [15:0] l);
      if (l < MIN_PAYLOAD) return MIN_PAYLOAD;
      if (l > MAX_PAYLOAD) return MAX_PAYLOAD;
      return l;
   endfunction

endpackage

// File: rtl/ipv4_csum.sv
// ipv4_csum: 10-word one's-complement adder tree
// with a registered, inverted result.
module ipv4_csum
   import udp_gen_pkg::*;
(
   input  logic             clk156,
   input  logic             eth_rst,
   input  logic             load,
   input  logic [9:0][15:0] words,
   output logic [15:0]      csum
);

   logic [16:0] l1 [5];
   logic [17:0] l2a, l2b;
   logic [18:0] l3;
   logic [19:0] sum;

   // Pairwise adder tree; carries are kept and folded at the end.
   always_comb begin
      for (int i = 0; i < 5; i++) begin
         l1[i] = {1'b0, words[2*i]} + {1'b0, words[2*i+1]};
      end
      l2a = 18'(l1[0]) + 18'(l1[1]);
      l2b = 18'(l1[2]) + 18'(l1[3]);
      l3  = 19'(l2a) + 19'(l2b);
      sum = 20'(l3) + 20'(l1[4]);
   end

   // Capture the checksum only while the frame is being prepared.
   always_ff @(posedge clk156 or posedge eth_rst) begin
      if (eth_rst) begin
         csum <= '0;
      end else if (load) begin
         csum <= ~csum_fold(sum);
      end
   end

endmodule

// File: rtl/udp_pkt_gen.sv
// udp_pkt_gen: back-to-back Ethernet/IPv4/UDP frame source
// on a 64-bit AXI4-Stream master, with per-frame sequence number.
module udp_pkt_gen
   import udp_gen_pkg::*;
#(
   parameter logic [47:0] ETH_DST   = 48'h90E2BA5D8DC9,
   parameter logic [47:0] ETH_SRC   = 48'h001122334455,
   parameter logic [31:0] IP_SADDR  = 32'hC0A80B01,
   parameter logic [31:0] IP_DADDR  = 32'hC0A80B03,
   parameter logic [15:0] UDP_SPORT = 16'h3776,
   parameter logic [15:0] UDP_DPORT = 16'h3776,
   parameter logic [7:0]  IP_TTL    = 8'h40
) (
   input  logic        clk156,
   input  logic        eth_rst,
   input  logic        enable,
   input  logic [15:0] payload_len,
   input  logic [15:0] gap_cycles,
   input  logic        m_axis_tready,
   output logic        m_axis_tvalid,
   output logic [63:0] m_axis_tdata,
   output logic [7:0]  m_axis_tkeep,
   output logic        m_axis_tlast,
   output logic        m_axis_tuser,
   output logic [31:0] frame_cnt,
   output logic        busy
);

   state_t state, state_n;

   logic [15:0] flen_q, tot_q, udp_q, gap_q;
   logic [7:0]  beat_q, last_q, keep_q;
   logic [31:0] seq_q;
   logic [15:0] csum_q;

   logic [15:0] len_c, flen_c, tot_c, udp_c, beats_c;
   logic [7:0]  keep_c;
   logic [9:0][15:0] csum_words;

   logic send, accept, is_last;

   logic [335:0] hdr_be;
   logic [7:0]   hdr_b [42];
   logic [63:0]  tdata_c;
   logic [15:0]  pos, off;
   logic [7:0]   bval;

   assign len_c   = clamp_len(payload_len);
   assign flen_c  = len_c + HDR_LEN;
   assign tot_c   = len_c + IP_HDR_LEN + UDP_HDR_LEN;
   assign udp_c   = len_c + UDP_HDR_LEN;
   assign beats_c = (flen_c + 16'd7) >> 3;
   assign keep_c  = (flen_c[2:0] == 3'd0) ? 8'hFF
                                          : ~(8'hFF << flen_c[2:0]);

   assign csum_words = {16'h4500, tot_c, seq_q[15:0], 16'h4000,
                        IP_TTL, IP_PROTO_UDP, 16'h0000,
                        IP_SADDR, IP_DADDR};

   ipv4_csum u_csum (
      .clk156 (clk156),
      .eth_rst(eth_rst),
      .load   (state == ST_PREP),
      .words  (csum_words),
      .csum   (csum_q)
   );

   assign send    = (state == ST_SEND);
   assign is_last = (beat_q == last_q);
   assign accept  = send && m_axis_tready;

   // State register.
   always_ff @(posedge clk156 or posedge eth_rst) begin
      if (eth_rst) state <= ST_IDLE;
      else         state <= state_n;
   end

   // Next state; GAP holds for max(gap,1) cycles so the
   // idle spacing is gap+2 with the IDLE and PREP cycles.
   always_comb begin
      state_n = state;
      unique case (state)
         ST_IDLE: if (enable) state_n = ST_PREP;
         ST_PREP: state_n = ST_SEND;
         ST_SEND: if (accept && is_last) state_n = ST_GAP;
         ST_GAP:  if (gap_q <= 16'd1) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Frame parameters, beat index, counters and gap timer.
   always_ff @(posedge clk156 or posedge eth_rst) begin
      if (eth_rst) begin
         flen_q    <= '0;
         tot_q     <= '0;
         udp_q     <= '0;
         gap_q     <= '0;
         beat_q    <= '0;
         last_q    <= '0;
         keep_q    <= '0;
         seq_q     <= '0;
         frame_cnt <= '0;
      end else begin
         unique case (1'b1)
            (state == ST_PREP): begin
               flen_q <= flen_c;
               tot_q  <= tot_c;
               udp_q  <= udp_c;
               last_q <= beats_c[7:0] - 8'd1;
               keep_q <= keep_c;
               beat_q <= '0;
            end
            (accept && is_last): begin
               frame_cnt <= frame_cnt + 32'd1;
               seq_q     <= seq_q + 32'd1;
               gap_q     <= gap_cycles;
            end
            (accept && !is_last): beat_q <= beat_q + 8'd1;
            (state == ST_GAP && gap_q > 16'd1): gap_q <= gap_q - 16'd1;
            default: ;
         endcase
      end
   end

   assign hdr_be = {ETH_DST, ETH_SRC, ETHERTYPE_IPV4,
                    8'h45, 8'h00, tot_q, seq_q[15:0], 16'h4000,
                    IP_TTL, IP_PROTO_UDP, csum_q, IP_SADDR, IP_DADDR,
                    UDP_SPORT, UDP_DPORT, udp_q, 16'h0000};

   // Header as wire-order bytes; byte 0 is the first on the wire.
   always_comb begin
      for (int i = 0; i < 42; i++) begin
         hdr_b[i] = hdr_be[335 - 8*i -: 8];
      end
   end

   // Beat mux: header, then seq bytes, then an incrementing pattern.
   always_comb begin
      tdata_c = '0;
      pos     = '0;
      off     = '0;
      bval    = '0;
      for (int k = 0; k < 8; k++) begin
         pos  = {5'd0, beat_q, 3'd0} + 16'(k);
         off  = pos - HDR_LEN;
         bval = 8'h00;
         if (pos >= flen_q) begin
            bval = 8'h00;
         end else if (pos < HDR_LEN) begin
            bval = hdr_b[pos[5:0]];
         end else if (off < 16'd4) begin
            unique case (off[1:0])
               2'd0:    bval = seq_q[31:24];
               2'd1:    bval = seq_q[23:16];
               2'd2:    bval = seq_q[15:8];
               default: bval = seq_q[7:0];
            endcase
         end else begin
            bval = off[7:0];
         end
         tdata_c[8*k +: 8] = bval;
      end
   end

   assign m_axis_tvalid = send;
   assign m_axis_tdata  = send ? tdata_c : '0;
   assign m_axis_tkeep  = send ? (is_last ? keep_q : 8'hFF) : '0;
   assign m_axis_tlast  = send && is_last;
   assign m_axis_tuser  = 1'b0;
   assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_udp_pkt_gen.sv
// tb_udp_pkt_gen: directed frame checks for udp_pkt_gen
// with hand-computed header, checksum and layout values.
module tb_udp_pkt_gen;

   logic        clk156 = 1'b0;
   logic        eth_rst = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] payload_len = 16'd18;
   logic [15:0] gap_cycles = 16'd0;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tvalid;
   logic [63:0] m_axis_tdata;
   logic [7:0]  m_axis_tkeep;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic [31:0] frame_cnt;
   logic        busy;

   int tests_run = 0;
   int tests_failed = 0;

   logic [7:0]  frm [2048];
   logic [63:0] beat0;
   logic [7:0]  lastkeep;
   int          nbeats, badkeep, stallbad;
   logic        capt_ok;

   udp_pkt_gen dut (
      .clk156       (clk156),
      .eth_rst      (eth_rst),
      .enable       (enable),
      .payload_len  (payload_len),
      .gap_cycles   (gap_cycles),
      .m_axis_tready(m_axis_tready),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tkeep (m_axis_tkeep),
      .m_axis_tlast (m_axis_tlast),
      .m_axis_tuser (m_axis_tuser),
      .frame_cnt    (frame_cnt),
      .busy         (busy)
   );

   always #3 clk156 = ~clk156;

   function automatic logic [15:0] w16(input int i);
      return {frm[i], frm[i+1]};
   endfunction

   function automatic logic [31:0] w32(input int i);
      return {frm[i], frm[i+1], frm[i+2], frm[i+3]};
   endfunction

   // Collect one frame at negedges; optionally stall on one beat.
   task automatic capture(input int stall_at, input int stall_n);
      int cyc, st;
      logic [63:0] hd;
      logic [7:0]  hk;
      logic        hl;
      cyc = 0; st = 0; hd = '0; hk = '0; hl = 1'b0;
      nbeats = 0; badkeep = 0; stallbad = 0;
      lastkeep = '0; beat0 = '0; capt_ok = 1'b0;
      while (!m_axis_tvalid && cyc < 5000) begin
         @(negedge clk156); cyc++;
      end
      while (m_axis_tvalid && cyc < 10000 && nbeats < 250) begin
         if (nbeats == stall_at && st < stall_n) begin
            if (st == 0) begin
               hd = m_axis_tdata; hk = m_axis_tkeep; hl = m_axis_tlast;
            end else if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {hd, hk, hl}) begin
               stallbad++;
            end
            m_axis_tready = 1'b0;
            st++;
         end else begin
            if (nbeats == stall_at && st > 0 &&
                {m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {hd, hk, hl})
               stallbad++;
            m_axis_tready = 1'b1;
            for (int k = 0; k < 8; k++) begin
               frm[nbeats*8+k] = m_axis_tdata[8*k +: 8];
               if (!m_axis_tkeep[k] && m_axis_tdata[8*k +: 8] !== 8'h00) badkeep++;
            end
            if (nbeats == 0) beat0 = m_axis_tdata;
            if (m_axis_tlast) begin
               lastkeep = m_axis_tkeep;
               nbeats++;
               capt_ok = 1'b1;
               @(negedge clk156);
               return;
            end
            if (m_axis_tkeep !== 8'hFF) badkeep++;
            nbeats++;
         end
         @(negedge clk156); cyc++;
      end
      tests_run++; tests_failed++;
      $display("FAIL capture: no complete frame, got %0d beats, required a tlast", nbeats);
   endtask

   task automatic start_one();
      enable = 1'b1;
      @(negedge clk156);
      enable = 1'b0;
   endtask

   task automatic wait_idle();
      int cyc;
      cyc = 0;
      while (busy && cyc < 200) begin
         @(negedge clk156); cyc++;
      end
      if (busy) begin
         tests_run++; tests_failed++;
         $display("FAIL wait_idle: busy=%b after 200 cycles, required 0", busy);
      end
   endtask

   task automatic test_reset();
      eth_rst = 1'b1;
      repeat (3) @(negedge clk156);
      tests_run++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_ctrl: valid/last/user/busy=%b required 0000",
                  {m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy});
      end
      tests_run++;
      if (m_axis_tdata !== 64'h0 || m_axis_tkeep !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_data: tdata=%h tkeep=%h required 0", m_axis_tdata, m_axis_tkeep);
      end
      tests_run++;
      if (frame_cnt !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_cnt: frame_cnt=%0d required 0", frame_cnt);
      end
      eth_rst = 1'b0;
      @(negedge clk156);
   endtask

   task automatic test_min_frame();
      payload_len = 16'd18; gap_cycles = 16'd0;
      start_one();
      capture(-1, 0);
      tests_run++;
      if (nbeats !== 8 || lastkeep !== 8'h0F) begin
         tests_failed++;
         $display("FAIL min_shape: beats=%0d keep=%h required 8 0F", nbeats, lastkeep);
      end
      tests_run++;
      if (beat0 !== 64'h1100C98D5DBAE290) begin
         tests_failed++;
         $display("FAIL min_beat0: got %h required 1100c98d5dbae290", beat0);
      end
      tests_run++;
      if (w16(12) !== 16'h0800 || w16(16) !== 16'h002E || w16(38) !== 16'h001A) begin
         tests_failed++;
         $display("FAIL min_lens: type=%h tot=%h udp=%h required 0800 002e 001a",
                  w16(12), w16(16), w16(38));
      end
      tests_run++;
      if (w16(24) !== 16'hA36A || w16(18) !== 16'h0000) begin
         tests_failed++;
         $display("FAIL min_csum: csum=%h id=%h required a36a 0000", w16(24), w16(18));
      end
      tests_run++;
      if (w32(26) !== 32'hC0A80B01 || w32(30) !== 32'hC0A80B03 || w32(34) !== 32'h37763776) begin
         tests_failed++;
         $display("FAIL min_addr: sa=%h da=%h ports=%h", w32(26), w32(30), w32(34));
      end
      tests_run++;
      if (badkeep !== 0) begin
         tests_failed++;
         $display("FAIL min_keep: %0d bad keep/pad bytes, required 0", badkeep);
      end
      repeat (5) @(negedge clk156);
      tests_run++;
      if (busy !== 1'b0 || m_axis_tvalid !== 1'b0 || frame_cnt !== 32'd1) begin
         tests_failed++;
         $display("FAIL min_stop: busy=%b valid=%b cnt=%0d required 0 0 1",
                  busy, m_axis_tvalid, frame_cnt);
      end
   endtask

   task automatic test_clamp();
      payload_len = 16'd5;
      start_one();
      capture(-1, 0);
      tests_run++;
      if (nbeats !== 8 || lastkeep !== 8'h0F || w16(16) !== 16'h002E) begin
         tests_failed++;
         $display("FAIL clamp_lo: beats=%0d keep=%h tot=%h required 8 0f 002e",
                  nbeats, lastkeep, w16(16));
      end
      tests_run++;
      if (w16(24) !== 16'hA369 || w32(42) !== 32'h1) begin
         tests_failed++;
         $display("FAIL clamp_lo_seq: csum=%h seq=%h required a369 1", w16(24), w32(42));
      end
      wait_idle();
      payload_len = 16'd2000;
      start_one();
      capture(-1, 0);
      tests_run++;
      if (nbeats !== 190 || lastkeep !== 8'h03) begin
         tests_failed++;
         $display("FAIL clamp_hi: beats=%0d keep=%h required 190 03", nbeats, lastkeep);
      end
      tests_run++;
      if (w16(16) !== 16'h05DC || w16(38) !== 16'h05C8 || w16(24) !== 16'h9DBA) begin
         tests_failed++;
         $display("FAIL clamp_hi_hdr: tot=%h udp=%h csum=%h required 05dc 05c8 9dba",
                  w16(16), w16(38), w16(24));
      end
      tests_run++;
      if (frm[1513] !== 8'hBF || badkeep !== 0) begin
         tests_failed++;
         $display("FAIL clamp_hi_tail: last byte=%h badkeep=%0d required bf 0",
                  frm[1513], badkeep);
      end
      wait_idle();
   endtask

   task automatic test_f64();
      int bad;
      payload_len = 16'd22;
      start_one();
      capture(-1, 0);
      tests_run++;
      if (nbeats !== 8 || lastkeep !== 8'hFF) begin
         tests_failed++;
         $display("FAIL f64_shape: beats=%0d keep=%h required 8 ff", nbeats, lastkeep);
      end
      tests_run++;
      if (w16(16) !== 16'h0032 || w16(38) !== 16'h001E || w16(24) !== 16'hA363) begin
         tests_failed++;
         $display("FAIL f64_hdr: tot=%h udp=%h csum=%h required 0032 001e a363",
                  w16(16), w16(38), w16(24));
      end
      bad = 0;
      for (int k = 4; k < 22; k++) if (frm[42+k] !== 8'(k)) bad++;
      tests_run++;
      if (bad !== 0 || w32(42) !== 32'h3) begin
         tests_failed++;
         $display("FAIL f64_payload: %0d bad bytes, seq=%h required 0 and 3", bad, w32(42));
      end
      wait_idle();
   endtask

   task automatic test_backpressure();
      payload_len = 16'd18;
      start_one();
      capture(2, 3);
      tests_run++;
      if (stallbad !== 0) begin
         tests_failed++;
         $display("FAIL bp_stable: %0d unstable stalled beats, required 0", stallbad);
      end
      tests_run++;
      if (nbeats !== 8 || lastkeep !== 8'h0F || badkeep !== 0) begin
         tests_failed++;
         $display("FAIL bp_shape: beats=%0d keep=%h badkeep=%0d required 8 0f 0",
                  nbeats, lastkeep, badkeep);
      end
      tests_run++;
      if (w16(24) !== 16'hA366 || w32(42) !== 32'h4 || w16(16) !== 16'h002E) begin
         tests_failed++;
         $display("FAIL bp_hdr: csum=%h seq=%h tot=%h required a366 4 002e",
                  w16(24), w32(42), w16(16));
      end
      wait_idle();
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_cs [3];
      int g;
      exp_cs[0] = 16'hA36A; exp_cs[1] = 16'hA369; exp_cs[2] = 16'hA368;
      eth_rst = 1'b1;
      @(negedge clk156);
      eth_rst = 1'b0;
      payload_len = 16'd18; gap_cycles = 16'd12;
      enable = 1'b1;
      for (int f = 0; f < 3; f++) begin
         if (f == 2) enable = 1'b0;
         capture(-1, 0);
         tests_run++;
         if (w16(18) !== 16'(f) || w32(42) !== 32'(f) || w16(24) !== exp_cs[f]) begin
            tests_failed++;
            $display("FAIL b2b_frame%0d: id=%h seq=%h csum=%h required %0d %0d %h",
                     f, w16(18), w32(42), w16(24), f, f, exp_cs[f]);
         end
         if (f < 2) begin
            g = 0;
            while (!m_axis_tvalid && g < 100) begin
               g++; @(negedge clk156);
            end
            tests_run++;
            if (g !== 14) begin
               tests_failed++;
               $display("FAIL b2b_gap%0d: %0d idle cycles, required 14", f, g);
            end
         end
      end
      tests_run++;
      if (frame_cnt !== 32'd3) begin
         tests_failed++;
         $display("FAIL b2b_cnt: frame_cnt=%0d required 3", frame_cnt);
      end
      wait_idle();
   endtask

   task automatic test_reset_midframe();
      int acc, cyc;
      payload_len = 16'd18; gap_cycles = 16'd0;
      enable = 1'b1;
      acc = 0; cyc = 0;
      @(negedge clk156);
      while (acc < 4 && cyc < 1000) begin
         if (m_axis_tvalid) acc++;
         @(negedge clk156); cyc++;
      end
      eth_rst = 1'b1;
      #1;
      tests_run++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || acc !== 4) begin
         tests_failed++;
         $display("FAIL rst_mid_valid: valid=%b last=%b beats=%0d required 0 0 4",
                  m_axis_tvalid, m_axis_tlast, acc);
      end
      tests_run++;
      if (frame_cnt !== 32'd0) begin
         tests_failed++;
         $display("FAIL rst_mid_cnt: frame_cnt=%0d required 0", frame_cnt);
      end
      @(negedge clk156);
      eth_rst = 1'b0;
      capture(-1, 0);
      enable = 1'b0;
      tests_run++;
      if (nbeats !== 8 || w16(18) !== 16'h0000 || w32(42) !== 32'h0 || w16(24) !== 16'hA36A) begin
         tests_failed++;
         $display("FAIL rst_mid_next: beats=%0d id=%h seq=%h csum=%h required 8 0 0 a36a",
                  nbeats, w16(18), w32(42), w16(24));
      end
      tests_run++;
      if (frame_cnt !== 32'd1) begin
         tests_failed++;
         $display("FAIL rst_mid_cnt2: frame_cnt=%0d required 1", frame_cnt);
      end
      wait_idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_min_frame();
      test_clamp();
      test_f64();
      test_backpressure();
      test_back_to_back();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
